// File: rtl/evaluate_poly_gf32.sv
// Horner evaluation of a byte-coefficient polynomial at T GF(2^32) points, sharing one external multiplier.
// Optional build macro EVAL_ZERO_SKIP_EN: bypass the multiplier whenever the current accumulator lane is zero.
module evaluate_poly_gf32 #(
    parameter string PARAMETER_SET = "L1",
    parameter int    N_COEFF       = (PARAMETER_SET == "L5") ? 480 : ((PARAMETER_SET == "L3") ? 352 : 230),
    parameter int    T             = (PARAMETER_SET == "L5") ? 4 : 3,
    localparam int   AW            = (N_COEFF > 1) ? $clog2(N_COEFF) : 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [7:0]      i_q_s,
    output logic [AW-1:0]   o_q_s_addr,
    output logic            o_q_s_rd,
    input  logic [32*T-1:0] i_r_eps,
    output logic [32*T-1:0] o_evaluate_out,
    output logic            o_done,
    output logic            o_busy,
    output logic            o_start_mul32,
    output logic [31:0]     o_x_mul32,
    output logic [31:0]     o_y_mul32,
    input  logic [31:0]     i_o_mul32,
    input  logic            i_done_mul32
);

    // state  | meaning
    // IDLE   | waiting for i_start
    // RD     | coefficient read strobe at current index
    // CAP    | capture coefficient byte, restart lane count
    // MSTART | launch multiply acc[31:0] * pts[31:0] (or bypass on zero lane)
    // MWAIT  | hold operands until the multiplier reports done
    // DONE   | publish accumulators, pulse o_done on the next cycle
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_MSTART,
        S_MWAIT,
        S_DONE
    } state_t;

    localparam int LW = (T > 1) ? $clog2(T) : 1;

    state_t          state;
    state_t          state_nxt;
    state_t          after_lane;
    logic [AW-1:0]   idx;
    logic [LW-1:0]   lane;
    logic [7:0]      coef;
    logic [32*T-1:0] acc;
    logic [32*T-1:0] pts;
    logic [32*T-1:0] acc_rot;
    logic [32*T-1:0] pts_rot;
    logic [31:0]     prod;
    logic [31:0]     lane_val;
    logic            last_lane;
    logic            last_coef;
    logic            skip;
    logic            lane_adv;

    assign last_lane = (lane == LW'(T - 1));
    assign last_coef = (idx == '0);

`ifdef EVAL_ZERO_SKIP_EN
    assign skip = (acc[31:0] == 32'd0);
`else
    assign skip = 1'b0;
`endif

    assign lane_adv = ((state == S_MSTART) && skip) || ((state == S_MWAIT) && i_done_mul32);
    assign prod     = (state == S_MWAIT) ? i_o_mul32 : 32'd0;
    assign lane_val = prod ^ {24'd0, coef};

    // New lane 0 value is written and then the whole register rotates right one lane.
    generate
        if (T > 1) begin : g_rot
            assign acc_rot = {lane_val, acc[32*T-1:32]};
            assign pts_rot = {pts[31:0], pts[32*T-1:32]};
        end else begin : g_rot_single
            assign acc_rot = lane_val;
            assign pts_rot = pts;
        end
    endgenerate

    assign o_q_s_addr = idx;
    assign o_x_mul32  = acc[31:0];
    assign o_y_mul32  = pts[31:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        after_lane    = S_DONE;
        o_busy        = (state != S_IDLE);
        o_q_s_rd      = 1'b0;
        o_start_mul32 = 1'b0;

        if (!last_lane) begin
            after_lane = S_MSTART;
        end else if (!last_coef) begin
            after_lane = S_RD;
        end

        case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_nxt = S_RD;
                end
            end
            S_RD: begin
                o_q_s_rd  = 1'b1;
                state_nxt = S_CAP;
            end
            S_CAP: begin
                state_nxt = S_MSTART;
            end
            S_MSTART: begin
                if (skip) begin
                    state_nxt = after_lane;
                end else begin
                    o_start_mul32 = 1'b1;
                    state_nxt     = S_MWAIT;
                end
            end
            S_MWAIT: begin
                if (i_done_mul32) begin
                    state_nxt = after_lane;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idx            <= '0;
            lane           <= '0;
            coef           <= '0;
            acc            <= '0;
            pts            <= '0;
            o_evaluate_out <= '0;
            o_done         <= 1'b0;
        end else begin
            o_done <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        pts  <= i_r_eps;
                        acc  <= '0;
                        idx  <= AW'(N_COEFF - 1);
                        lane <= '0;
                    end
                end
                S_CAP: begin
                    coef <= i_q_s;
                    lane <= '0;
                end
                S_MSTART, S_MWAIT: begin
                    if (lane_adv) begin
                        acc <= acc_rot;
                        pts <= pts_rot;
                        if (last_lane) begin
                            lane <= '0;
                            // Index 0 is terminal: no decrement, so no underflow read.
                            if (!last_coef) begin
                                idx <= idx - AW'(1);
                            end
                        end else begin
                            lane <= lane + LW'(1);
                        end
                    end
                end
                S_DONE: begin
                    o_evaluate_out <= acc;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_evaluate_poly_gf32.sv
// Directed bench for evaluate_poly_gf32: an L1 instance and a 4-coefficient instance share
// one coefficient memory model and one GF(2^32) multiplier model with programmable latency.
module tb_evaluate_poly_gf32;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        sel = 1'b0;
    logic [7:0]  i_q_s = 8'd0;
    logic [95:0] eps = '0;
    logic        mdl_done = 1'b0;
    logic [31:0] mdl_prod = 32'd0;
    logic        stray_done = 1'b0;
    logic        done_w;
    logic [31:0] prod_w;

    logic [7:0]  l1_addr;
    logic        l1_rd, l1_done, l1_busy, l1_ms;
    logic [31:0] l1_x, l1_y;
    logic [95:0] l1_eval;
    logic [1:0]  sm_addr;
    logic        sm_rd, sm_done, sm_busy, sm_ms;
    logic [31:0] sm_x, sm_y;
    logic [95:0] sm_eval;

    logic        m_rd, m_done, m_busy, m_start;
    logic [31:0] m_x, m_y;
    logic [95:0] m_eval;
    int          m_addr;

    logic [7:0]  mem [0:255];
    int          rd_log[$];
    int          n_mstart = 0;
    int          hold_err = 0;
    int unsigned w_fix = 1;
    int          tests = 0;
    int          fails = 0;

    always #5 i_clk = ~i_clk;

    assign done_w = mdl_done | stray_done;
    assign prod_w = stray_done ? 32'hDEAD_BEEF : mdl_prod;

    evaluate_poly_gf32 #(.PARAMETER_SET("L1")) dut_l1 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start & ~sel), .i_q_s(i_q_s),
        .o_q_s_addr(l1_addr), .o_q_s_rd(l1_rd), .i_r_eps(eps), .o_evaluate_out(l1_eval),
        .o_done(l1_done), .o_busy(l1_busy), .o_start_mul32(l1_ms), .o_x_mul32(l1_x),
        .o_y_mul32(l1_y), .i_o_mul32(prod_w), .i_done_mul32(done_w)
    );

    evaluate_poly_gf32 #(.PARAMETER_SET("L1"), .N_COEFF(4), .T(3)) dut_sm (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start & sel), .i_q_s(i_q_s),
        .o_q_s_addr(sm_addr), .o_q_s_rd(sm_rd), .i_r_eps(eps), .o_evaluate_out(sm_eval),
        .o_done(sm_done), .o_busy(sm_busy), .o_start_mul32(sm_ms), .o_x_mul32(sm_x),
        .o_y_mul32(sm_y), .i_o_mul32(prod_w), .i_done_mul32(done_w)
    );

    assign m_rd    = sel ? sm_rd : l1_rd;
    assign m_done  = sel ? sm_done : l1_done;
    assign m_busy  = sel ? sm_busy : l1_busy;
    assign m_start = sel ? sm_ms : l1_ms;
    assign m_x     = sel ? sm_x : l1_x;
    assign m_y     = sel ? sm_y : l1_y;
    assign m_eval  = sel ? sm_eval : l1_eval;
    assign m_addr  = sel ? int'(sm_addr) : int'(l1_addr);

    // Field polynomial x^32 + x^22 + x^2 + x + 1.
    function automatic logic [31:0] gf_mul(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic [31:0] aa;
        r  = 32'd0;
        aa = a;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) r = r ^ aa;
            aa = aa[31] ? ((aa << 1) ^ 32'h0040_0007) : (aa << 1);
        end
        return r;
    endfunction

    function automatic logic [31:0] horner(input logic [31:0] r, input int n);
        logic [31:0] a;
        a = 32'd0;
        for (int i = n - 1; i >= 0; i--) a = gf_mul(a, r) ^ {24'd0, mem[i]};
        return a;
    endfunction

    // Coefficient memory: junk during the read cycle, real byte one cycle after the request.
    always begin
        int ra;
        @(negedge i_clk);
        if (m_rd) begin
            ra = m_addr;
            rd_log.push_back(ra);
            i_q_s = 8'h5A;
            @(posedge i_clk);
            #1;
            i_q_s = mem[ra];
        end
    end

    // Multiplier: done arrives in the W-th MWAIT cycle; operands must stay put while waiting.
    always begin
        logic [31:0] mx, my;
        int unsigned w;
        bit abort;
        @(negedge i_clk);
        while (m_start) begin
            n_mstart++;
            mx    = m_x;
            my    = m_y;
            w     = (w_fix != 0) ? w_fix : $urandom_range(1, 5);
            abort = 1'b0;
            for (int k = 0; k < int'(w); k++) begin
                @(negedge i_clk);
                if (!i_rst_n) abort = 1'b1;
                else if (!abort && (m_x !== mx || m_y !== my)) hold_err++;
            end
            if (!abort) begin
                mdl_prod = gf_mul(mx, my);
                mdl_done = 1'b1;
                @(negedge i_clk);
                mdl_done = 1'b0;
                mdl_prod = 32'd0;
            end
        end
    end

    task automatic do_run(input int budget, output int cyc, output bit timed_out);
        @(negedge i_clk);
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start   = 1'b0;
        cyc       = 0;
        timed_out = 1'b1;
        while (cyc < budget) begin
            @(posedge i_clk);
            #1;
            cyc++;
            if (m_done) begin
                timed_out = 1'b0;
                break;
            end
        end
        tests++;
        if (timed_out) begin
            fails++;
            $display("FAIL run_timeout: no o_done within %0d cycles", budget);
        end
    endtask

    task automatic check_lanes(input string name);
        logic [31:0] exp;
        for (int t = 0; t < 3; t++) begin
            exp = horner(eps[32*t +: 32], 4);
            tests++;
            if (m_eval[32*t +: 32] !== exp) begin
                fails++;
                $display("FAIL %s lane%0d: got %08h expected %08h", name, t, m_eval[32*t +: 32], exp);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge i_clk);
        #1;
        tests++;
        if ({l1_done, l1_busy, l1_rd, l1_ms, sm_done, sm_busy, sm_rd, sm_ms} !== 8'd0) begin
            fails++;
            $display("FAIL reset_ctrl: got %08b expected 00000000",
                     {l1_done, l1_busy, l1_rd, l1_ms, sm_done, sm_busy, sm_rd, sm_ms});
        end
        tests++;
        if (l1_addr !== 8'd0 || l1_x !== 32'd0 || l1_y !== 32'd0 || l1_eval !== 96'd0) begin
            fails++;
            $display("FAIL reset_data: addr %0h x %08h y %08h eval %024h expected all 0",
                     l1_addr, l1_x, l1_y, l1_eval);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_zero_l1();
        int cyc;
        bit to;
        int n0;
        sel   = 1'b0;
        w_fix = 1;
        for (int i = 0; i < 256; i++) mem[i] = 8'd0;
        eps = {32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_F0F0};
        n0  = n_mstart;
        do_run(3000, cyc, to);
        tests++;
        if (m_eval !== 96'd0) begin
            fails++;
            $display("FAIL zero_result: got %024h expected 0", m_eval);
        end
`ifdef EVAL_ZERO_SKIP_EN
        tests++;
        if (n_mstart - n0 != 0) begin
            fails++;
            $display("FAIL zero_skip_starts: got %0d expected 0", n_mstart - n0);
        end
`else
        tests++;
        if (cyc != 1841) begin
            fails++;
            $display("FAIL l1_latency: got %0d expected 1841", cyc);
        end
        tests++;
        if (n_mstart - n0 != 690) begin
            fails++;
            $display("FAIL l1_mul_starts: got %0d expected 690", n_mstart - n0);
        end
`endif
        @(negedge i_clk);
    endtask

    task automatic test_ones();
        int cyc;
        bit to;
        int base;
        sel   = 1'b1;
        w_fix = 1;
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04;
        eps  = {32'h0000_0001, 32'h0000_0001, 32'h0000_0001};
        base = rd_log.size();
        do_run(200, cyc, to);
        tests++;
        if (m_eval !== {32'h4, 32'h4, 32'h4}) begin
            fails++;
            $display("FAIL ones_result: got %024h expected 000000040000000400000004", m_eval);
        end
`ifndef EVAL_ZERO_SKIP_EN
        tests++;
        if (cyc != 33) begin
            fails++;
            $display("FAIL small_latency: got %0d expected 33", cyc);
        end
`endif
        tests++;
        if (rd_log.size() - base != 4) begin
            fails++;
            $display("FAIL read_count: got %0d expected 4", rd_log.size() - base);
        end else begin
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (rd_log[base + k] != 3 - k) begin
                    fails++;
                    $display("FAIL read_order%0d: got %0d expected %0d", k, rd_log[base + k], 3 - k);
                end
            end
        end
        @(negedge i_clk);
    endtask

    task automatic test_random();
        int cyc;
        bit to;
        sel   = 1'b1;
        w_fix = 0;
        for (int i = 0; i < 4; i++) mem[i] = 8'($urandom_range(0, 255));
        eps = {$urandom, $urandom, $urandom};
        do_run(500, cyc, to);
        check_lanes("random");
        @(posedge i_clk);
        #1;
        tests++;
        if (m_done !== 1'b0) begin
            fails++;
            $display("FAIL done_width: o_done still %b one cycle later, expected 0", m_done);
        end
        @(negedge i_clk);
    endtask

    task automatic test_busy_ignore();
        int cyc;
        bit to;
        sel   = 1'b1;
        w_fix = 0;
        @(negedge i_clk);
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        @(negedge i_clk);
        stray_done = 1'b1;
        @(negedge i_clk);
        stray_done = 1'b0;
        i_start    = 1'b1;
        repeat (20) @(negedge i_clk);
        i_start = 1'b0;
        to  = 1'b1;
        cyc = 0;
        while (cyc < 500) begin
            @(posedge i_clk);
            #1;
            cyc++;
            if (m_done) begin
                to = 1'b0;
                break;
            end
        end
        tests++;
        if (to) begin
            fails++;
            $display("FAIL busy_timeout: no o_done within 500 cycles");
        end
        check_lanes("busy_ignore");
        repeat (3) @(posedge i_clk);
        #1;
        tests++;
        if (m_busy !== 1'b0) begin
            fails++;
            $display("FAIL busy_restart: o_busy %b expected 0", m_busy);
        end
        @(negedge i_clk);
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit to;
        int n;
        int seen_done;
        sel   = 1'b1;
        w_fix = 5;
        @(negedge i_clk);
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        n = 0;
        while (!m_start && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        tests++;
        if (!m_start) begin
            fails++;
            $display("FAIL mid_no_start: o_start_mul32 %b expected 1", m_start);
        end
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        tests++;
        if ({m_done, m_busy, m_rd, m_start} !== 4'd0 || m_addr != 0) begin
            fails++;
            $display("FAIL mid_reset_ctrl: got %04b addr %0d expected 0000 addr 0",
                     {m_done, m_busy, m_rd, m_start}, m_addr);
        end
        tests++;
        if (m_x !== 32'd0 || m_y !== 32'd0 || m_eval !== 96'd0) begin
            fails++;
            $display("FAIL mid_reset_data: x %08h y %08h eval %024h expected all 0", m_x, m_y, m_eval);
        end
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        stray_done = 1'b1;
        @(negedge i_clk);
        stray_done = 1'b0;
        seen_done  = 0;
        repeat (10) begin
            @(negedge i_clk);
            if (m_done) seen_done++;
        end
        tests++;
        if (m_busy !== 1'b0 || seen_done != 0 || m_eval !== 96'd0) begin
            fails++;
            $display("FAIL stale_done: busy %b dones %0d eval %024h expected 0 0 0", m_busy, seen_done, m_eval);
        end
        w_fix = 0;
        for (int i = 0; i < 4; i++) mem[i] = 8'($urandom_range(0, 255));
        eps = {$urandom, $urandom, $urandom};
        do_run(500, cyc, to);
        check_lanes("after_reset");
        @(negedge i_clk);
    endtask

    task automatic test_hold();
        tests++;
        if (hold_err != 0) begin
            fails++;
            $display("FAIL operand_hold: %0d operand changes during MWAIT, expected 0", hold_err);
        end
    endtask

    initial begin
        test_reset();
        test_zero_l1();
        test_ones();
        test_random();
        test_busy_ignore();
        test_reset_mid();
        test_hold();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/evaluate_poly_gf32.md
EVALUATE_POLY_GF32 -- requirements
Module: evaluate_poly_gf32

Interface
REQ-001 SHALL have parameter PARAMETER_SET, default "L1"; selects the set L1/L3/L5.
REQ-002 SHALL have parameter N_COEFF, default 230 (L1), 352 (L3), 480 (L5); number of polynomial coefficients.
REQ-003 SHALL have parameter T, default 4 for L5 and 3 otherwise; number of GF(2^32) evaluation points.
REQ-004 SHALL have port i_clk  input  1  clock; all logic is on the rising edge.
REQ-005 SHALL have port i_rst_n  input  1  reset; one clock; asynchronous, active-low.
REQ-006 SHALL have port i_start  input  1  start pulse; sampled only in IDLE.
REQ-007 SHALL have port i_q_s  input  8  coefficient byte, valid one cycle after the read request.
REQ-008 SHALL have port o_q_s_addr  output  CLOG2(N_COEFF)  coefficient address.
REQ-009 SHALL have port o_q_s_rd  output  1  coefficient read strobe.
REQ-010 SHALL have port i_r_eps  input  32*T  evaluation points; lane t is bits [32t+31:32t].
REQ-011 SHALL have port o_evaluate_out  output  32*T  results, lane-aligned with i_r_eps.
REQ-012 SHALL have port o_done  output  1  single-cycle completion pulse.
REQ-013 SHALL have port o_busy  output  1  high in every state except IDLE.
REQ-014 SHALL have ports o_start_mul32 (out, 1), o_x_mul32 (out, 32), o_y_mul32 (out, 32), i_o_mul32 (in, 32), i_done_mul32 (in, 1); together they form the external GF32 multiplier handshake.

Function
REQ-015 SHALL compute, per lane, P(r_t) = sum of c_i * r_t^i over GF(2^32) by Horner's rule, where c_i = byte at address i, zero-extended into bits [7:0].
REQ-016 SHALL latch i_r_eps and clear all T accumulators on the cycle i_start is accepted.
REQ-017 SHALL process coefficients from address N_COEFF-1 down to 0.
REQ-018 SHALL use FSM states IDLE -> RD -> CAP -> MSTART -> MWAIT -> (MSTART for the next lane | RD for the next coefficient | DONE) -> IDLE.
REQ-019 SHALL, in RD, assert o_q_s_rd for one cycle with o_q_s_addr set to the current index.
REQ-020 SHALL, in CAP, register i_q_s as the current coefficient and set the lane counter to 0.
REQ-021 SHALL, in MSTART, assert o_start_mul32 for exactly one cycle, with o_x_mul32 = accumulator lane [31:0] and o_y_mul32 = latched point lane [31:0].
REQ-022 SHALL hold o_x_mul32 and o_y_mul32 stable throughout MWAIT.
REQ-023 SHALL, on the MWAIT cycle where i_done_mul32=1, write i_o_mul32 XOR coefficient into lane [31:0], then rotate both the accumulator and the point register right by 32 bits.
REQ-024 SHALL ignore i_done_mul32 outside MWAIT and ignore i_start while o_busy=1.
REQ-025 SHALL go to DONE after lane T-1 of address 0; DONE pulses o_done for 1 cycle and copies the accumulators to o_evaluate_out.
REQ-026 SHALL hold o_evaluate_out until the next DONE.
REQ-027 SHALL take N_COEFF*(2 + T*(1+W)) + 1 cycles from start acceptance to o_done, where W = MWAIT cycles per multiply including the done cycle.
REQ-028 SHALL decrement the address without wrap; index 0 is terminal, with no underflow read.

Reset
REQ-029 SHALL, while i_rst_n=0, force state IDLE and drive o_done, o_busy, o_q_s_rd, o_start_mul32, o_q_s_addr, o_x_mul32, o_y_mul32, o_evaluate_out, the accumulators and the counters to 0.
REQ-030 SHALL, on reset mid-operation, abandon the outstanding multiply; after release, a stale i_done_mul32 SHALL have no effect.

Configuration
REQ-031 SHALL, with macro EVAL_ZERO_SKIP_EN defined, skip MSTART/MWAIT whenever accumulator lane [31:0] is zero: product taken as 0, XOR and rotate done in one cycle, no o_start_mul32.
REQ-032 SHALL, without EVAL_ZERO_SKIP_EN, always issue a multiply per lane per coefficient, giving the latency in REQ-027.

Verification
REQ-033 SHALL cover: L1, mul model W=1, all-zero coefficients -> o_evaluate_out=0; o_done at 1841 cycles without the macro; no mul starts with the macro.
REQ-034 SHALL cover: N_COEFF=4, coefficients {0x01,0x02,0x03,0x04}, all points 0x00000001 -> every lane = 0x00000004.
REQ-035 SHALL cover: N_COEFF=4, T=3, random points and coefficients, W randomized 1..5 -> every lane matches a reference Horner model; o_done width exactly 1.
REQ-036 SHALL cover: i_start re-asserted while busy, and i_done_mul32 pulsed during RD -> results unchanged versus the clean run.
REQ-037 SHALL cover: i_rst_n low during MWAIT, then a stray i_done_mul32, then a new i_start -> outputs 0 during reset; the second run is correct.
